// File: rtl/stream_conv_1_2.sv
// -----------------------------------------------------------------------------
// stream_conv_1_2
// Splits a DATA_WIDTH-bit valid/ready input stream into two DATA_WIDTH/2 lanes
// that fire together. Input words are buffered in a DEPTH-entry FIFO and
// drained in bursts of ACTIVE_SAMPLES words separated by IDLE_CYCLES quiet
// clocks. After TOTAL_SAMPLES words the block stops accepting and emitting
// until the next reset.
//
// Ports
//   clk        in   1             rising-edge clock
//   resetn     in   1             asynchronous active-low reset
//   s_valid    in   1             input word valid
//   s_data     in   DATA_WIDTH    input word
//   s_ready    out  1             input accepts a word this cycle
//   data_port1 out  DATA_WIDTH/2  lower half of the emitted word
//   valid1     out  1             one-cycle pulse per emitted word
//   data_port2 out  DATA_WIDTH/2  upper half of the emitted word
//   valid2     out  1             identical to valid1
// -----------------------------------------------------------------------------
module stream_conv_1_2 #(
    parameter int DATA_WIDTH     = 64,
    parameter int TOTAL_SAMPLES  = 733824,
    parameter int DEPTH          = 4096,
    parameter int ACTIVE_SAMPLES = 3276,
    parameter int IDLE_CYCLES    = 1172
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    s_ready,
    output logic [DATA_WIDTH/2-1:0] data_port1,
    output logic                    valid1,
    output logic [DATA_WIDTH/2-1:0] data_port2,
    output logic                    valid2
);

    localparam int HW = DATA_WIDTH / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TOTAL_SAMPLES + 1);
    localparam int BW = $clog2(ACTIVE_SAMPLES + 1);
    // Keep the idle counter at least one bit wide even when there is no gap.
    localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [CW-1:0]         r_in_cnt;
    logic [CW-1:0]         r_out_cnt;
    logic [BW-1:0]         r_burst_cnt;
    logic [IW-1:0]         r_idle_cnt;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_valid;
    logic [HW-1:0]         r_data_lo;
    logic [HW-1:0]         r_data_hi;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_burst_end;

    // The extra pointer bit distinguishes a full FIFO from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Ready depends only on registered state, so a same-cycle pop never raises it.
    assign s_ready = resetn && !w_full && (r_in_cnt < CW'(TOTAL_SAMPLES));
    assign w_push  = s_valid && s_ready;

    assign w_burst_end = (r_burst_cnt == BW'(ACTIVE_SAMPLES - 1));

    assign data_port1 = r_data_lo;
    assign data_port2 = r_data_hi;
    assign valid1     = r_valid;
    assign valid2     = r_valid;

    // Next-state and pop decision for the burst/idle/done output sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (r_out_cnt == CW'(TOTAL_SAMPLES - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_burst_end && (IDLE_CYCLES > 0)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_IDLE: begin
                if (r_idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_data;
        end
    end

    // FIFO pointers and the accepted-word counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                r_in_cnt <= r_in_cnt + CW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Burst, idle and emitted-word counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt   <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_out_cnt   <= r_out_cnt + CW'(1);
                r_burst_cnt <= w_burst_end ? '0 : (r_burst_cnt + BW'(1));
            end
            // Counts clocks spent in IDLE; zero on entry to IDLE.
            if (r_state == ST_IDLE) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    // Registered output lanes; data holds its last value between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_data_lo <= '0;
            r_data_hi <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_data_lo <= r_mem[r_rd_ptr[AW-1:0]][HW-1:0];
                r_data_hi <= r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH-1:HW];
            end
        end
    end

endmodule

// File: tb/tb_stream_conv_1_2.sv
// -----------------------------------------------------------------------------
// Testbench for stream_conv_1_2 with a small configuration (ACTIVE=4, IDLE=3,
// DEPTH=4, TOTAL=12). A queue-based reference model tracks accepted words,
// burst position and remaining gap, and predicts ready, valid and lane data
// every clock.
// -----------------------------------------------------------------------------
module tb_stream_conv_1_2;

    localparam int DW    = 64;
    localparam int TOTAL = 12;
    localparam int DEPTH = 4;
    localparam int ACT   = 4;
    localparam int IDLE  = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [31:0]   data_port1;
    logic          valid1;
    logic [31:0]   data_port2;
    logic          valid2;

    always #5 clk = ~clk;

    stream_conv_1_2 #(
        .DATA_WIDTH    (DW),
        .TOTAL_SAMPLES (TOTAL),
        .DEPTH         (DEPTH),
        .ACTIVE_SAMPLES(ACT),
        .IDLE_CYCLES   (IDLE)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .data_port1(data_port1),
        .valid1    (valid1),
        .data_port2(data_port2),
        .valid2    (valid2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    int            accepted;
    int            emitted;
    int            in_burst;
    int            gap_left;
    bit            done;
    logic          exp_valid;
    logic [DW-1:0] exp_word;

    // Observation helpers.
    int            n_out;
    int            n_acc;
    bit            saw_full;
    logic [24:0]   vhist;
    int            cyc;
    int            times[$];
    int            gap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return (resetn === 1'b1) && (q.size() < DEPTH) && (accepted < TOTAL);
    endfunction

    task automatic model_reset();
        q.delete();
        accepted  = 0;
        emitted   = 0;
        in_burst  = 0;
        gap_left  = 0;
        done      = 1'b0;
        exp_valid = 1'b0;
        exp_word  = '0;
    endtask

    // One clock of the reference: emission uses the queue as it was before the edge.
    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit rdy);
        exp_valid = 1'b0;
        if (!done && gap_left == 0 && q.size() > 0) begin
            exp_word  = q.pop_front();
            exp_valid = 1'b1;
            emitted++;
            in_burst++;
            if (emitted == TOTAL) begin
                done = 1'b1;
            end else if (in_burst == ACT) begin
                in_burst = 0;
                gap_left = IDLE;
            end
        end else if (!done && gap_left > 0) begin
            gap_left--;
        end
        if (v && rdy) begin
            q.push_back(d);
            accepted++;
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drive one clock of stimulus and check ready before and outputs after the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d);
        bit rdy;
        s_valid = v;
        s_data  = d;
        #1;
        rdy = model_ready();
        chk("s_ready", {63'd0, s_ready}, {63'd0, rdy});
        if (!s_ready && accepted < TOTAL) saw_full = 1'b1;
        if (v && s_ready) n_acc++;
        @(posedge clk);
        model_edge(v, d, rdy);
        #1;
        chk("valid1", {63'd0, valid1}, {63'd0, exp_valid});
        chk("valid2", {63'd0, valid2}, {63'd0, exp_valid});
        chk("data_port1", {32'd0, data_port1}, {32'd0, exp_word[31:0]});
        chk("data_port2", {32'd0, data_port2}, {32'd0, exp_word[63:32]});
        if (valid1 === 1'b1) begin
            n_out++;
            times.push_back(cyc);
        end
        vhist = {vhist[23:0], valid1};
        cyc++;
    endtask

    // Assert reset mid-cycle with s_valid high, verify immediate clearing, then release.
    task automatic do_reset();
        resetn  = 1'b0;
        s_valid = 1'b1;
        s_data  = rnd64();
        #1;
        model_reset();
        chk("rst_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_valid1", {63'd0, valid1}, 64'd0);
        chk("rst_valid2", {63'd0, valid2}, 64'd0);
        chk("rst_port1", {32'd0, data_port1}, 64'd0);
        chk("rst_port2", {32'd0, data_port2}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_hold_valid", {63'd0, valid1}, 64'd0);
        resetn = 1'b1;
        n_out    = 0;
        n_acc    = 0;
        saw_full = 1'b0;
        vhist    = '0;
        cyc      = 0;
        times.delete();
    endtask

    initial begin
        resetn  = 1'b0;
        s_valid = 1'b1;
        s_data  = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single word: halves appear one cycle after the push, for one cycle only.
        cycle(1'b1, 64'h1122334455667788);
        cycle(1'b0, rnd64());
        chk("single_valid", {63'd0, valid1}, 64'd1);
        chk("single_port1", {32'd0, data_port1}, 64'h55667788);
        chk("single_port2", {32'd0, data_port2}, 64'h11223344);
        cycle(1'b0, rnd64());
        chk("single_pulse_end", {63'd0, valid1}, 64'd0);

        // Reset with data held on the ports; then burst shape under continuous input.
        do_reset();
        for (int i = 0; i < 25; i++) cycle(1'b1, rnd64());
        chk("burst_pattern", {39'd0, vhist}, {39'd0, 25'b0111100011110001111000000});
        chk("backpressure_seen", {63'd0, saw_full}, 64'd1);
        chk("ready_after_total", {63'd0, s_ready}, 64'd0);
        chk("burst_out_count", n_out, TOTAL);
        chk("burst_acc_count", n_acc, TOTAL);

        // Underflow: one word every third clock.
        do_reset();
        for (int i = 0; i < 50; i++) cycle((i % 3) == 0, rnd64());
        chk("underflow_count", times.size(), TOTAL);
        gap = (times.size() >= 2) ? (times[1] - times[0]) : -1;
        chk("underflow_spacing", gap, 3);

        // Mid-run reset after 5 words, then a fresh run with random valid.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd64());
        chk("midrun_acc", n_acc, 5);
        do_reset();
        for (int i = 0; i < 90; i++) cycle(($urandom % 2) == 1, rnd64());
        chk("rerun_acc_count", n_acc, TOTAL);
        chk("rerun_out_count", n_out, TOTAL);
        chk("rerun_ready_low", {63'd0, s_ready}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
